// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping.
module rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             found,
    output logic [IW-1:0]    next
);

    logic [IW-1:0] cand;

    // Scan last+1 .. last+N_REQ; the final step revisits 'last' itself.
    always_comb begin
        found = 1'b0;
        next  = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IW'((32'(last) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                next  = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned IW         = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                        fifo_full,
    output logic [N_REQ-1:0]            gnt,
    output logic                        fifo_wr,
    output logic [DATA_WIDTH-1:0]       fifo_wdata,
    output logic [IW-1:0]               owner,
    output logic                        busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] count_q, count_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          req_own_c;
    logic          accept_c;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req   (req),
        .last  (owner_q),
        .found (pick_found),
        .next  (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= IW'(N_REQ - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    assign req_own_c = req[owner_q];
    assign accept_c  = (state_q == ARB_BURST) && req_own_c && !fifo_full;

    // Next-state: arbitrate in IDLE, count accepted words in BURST.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        count_d = count_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_BURST;
                    owner_d = pick_idx;
                    count_d = '0;
                end
            end
            ARB_BURST: begin
                if (accept_c) begin
                    if (count_q == CW'(MAX_BURST - 1)) begin
                        state_d = ARB_IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else if (!req_own_c) begin
                    state_d = ARB_IDLE;
                    count_d = '0;
                end
            end
        endcase
    end

    // Same-cycle consume strobe and write data for the current owner.
    always_comb begin
        gnt        = '0;
        fifo_wdata = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (owner_q == IW'(i)) begin
                gnt[i] = accept_c;
                if (accept_c) begin
                    fifo_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign fifo_wr = accept_c;
    assign owner   = owner_q;
    assign busy    = (state_q == ARB_BURST);

endmodule
